// File: rtl/fft_bf_scheduler_if.sv
// ============================================================================
// Module      : fft_bf_scheduler_if
// Description : Control/address bundle between the FFT butterfly scheduler and
//               the RAM / twiddle ROM / butterfly datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_bf_scheduler_if #(
    parameter int N_POINTS = 64
);
    localparam int LOG2N = $clog2(N_POINTS);

    logic             start;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic             bf_enable;
    logic             bf_out_valid;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;
    logic [LOG2N-1:0] stage_idx;
    logic             sync_err;

    modport master (
        input  start, bf_out_valid,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_enable,
               wr_en, wr_addr_a, wr_addr_b, stage_idx, sync_err
    );

    modport slave (
        output start, bf_out_valid,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_enable,
               wr_en, wr_addr_a, wr_addr_b, stage_idx, sync_err
    );
endinterface

`default_nettype wire

// File: rtl/fft_bf_scheduler.sv
// ============================================================================
// Module      : fft_bf_scheduler
// Description : Sequences one shared radix-2 butterfly through an in-place
//               DIF FFT; issues reads/twiddles, drains between stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_bf_scheduler #(
    parameter int N_POINTS   = 64,
    parameter int MEM_RD_LAT = 1,
    parameter int BF_LATENCY = 3,
    parameter int TW_RD_LAT  = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    fft_bf_scheduler_if.master bus
);
    localparam int LOG2N  = $clog2(N_POINTS);
    localparam int HALF   = N_POINTS / 2;
    localparam int KW     = LOG2N - 1;
    localparam int D      = MEM_RD_LAT + BF_LATENCY;
    localparam int DW     = $clog2(D + 1);
    localparam int TW_DLY = MEM_RD_LAT + 1 - TW_RD_LAT;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t           r_state;
    logic [KW-1:0]    r_k;
    logic [LOG2N-1:0] r_stage;
    logic [DW-1:0]    r_dcnt;
    logic             r_busy, r_done, r_rd_en, r_sync_err;
    logic [LOG2N-1:0] r_rd_addr_a, r_rd_addr_b;
    logic [KW-1:0]    r_tw_iss;
    logic [KW-1:0]    w_tw_out;

    logic             r_pv [1:D];
    logic [LOG2N-1:0] r_pa [1:D];
    logic [LOG2N-1:0] r_pb [1:D];

    logic [KW-1:0]    w_nk;
    logic [LOG2N-1:0] w_ns, w_na, w_nb;
    logic [KW-1:0]    w_ntw;

    function automatic logic [LOG2N-1:0] span_of(input logic [LOG2N-1:0] s);
        return LOG2N'(N_POINTS >> (int'(s) + 1));
    endfunction

    // Split k at the span boundary: high part moves up one bit, low part stays.
    function automatic logic [LOG2N-1:0] addr_a_of(input logic [KW-1:0] k,
                                                   input logic [LOG2N-1:0] s);
        logic [LOG2N-1:0] kk;
        logic [LOG2N-1:0] mask;
        kk   = {1'b0, k};
        mask = span_of(s) - 1'b1;
        return ((kk & ~mask) << 1) | (kk & mask);
    endfunction

    function automatic logic [KW-1:0] tw_of(input logic [KW-1:0] k,
                                            input logic [LOG2N-1:0] s);
        logic [LOG2N-1:0] kk;
        logic [LOG2N-1:0] mask;
        kk   = {1'b0, k};
        mask = span_of(s) - 1'b1;
        return KW'((kk & mask) << s);
    endfunction

    // Operands of the butterfly to be issued on the next cycle, if any.
    always_comb begin
        w_nk = '0;
        w_ns = '0;
        if (r_state == ISSUE) begin
            w_nk = r_k + 1'b1;
            w_ns = r_stage;
        end else if (r_state == DRAIN) begin
            w_ns = r_stage + 1'b1;
        end
        w_na  = addr_a_of(w_nk, w_ns);
        w_nb  = w_na | span_of(w_ns);
        w_ntw = tw_of(w_nk, w_ns);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_stage     <= '0;
            r_dcnt      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_tw_iss    <= '0;
            r_sync_err  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_sync_err <= r_sync_err | (bus.bf_out_valid != r_pv[D]);
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state     <= ISSUE;
                        r_k         <= '0;
                        r_stage     <= '0;
                        r_busy      <= 1'b1;
                        r_sync_err  <= 1'b0;
                        r_rd_en     <= 1'b1;
                        r_rd_addr_a <= w_na;
                        r_rd_addr_b <= w_nb;
                        r_tw_iss    <= w_ntw;
                    end
                end
                ISSUE: begin
                    if (r_k == KW'(HALF - 1)) begin
                        r_state <= DRAIN;
                        r_dcnt  <= '0;
                    end else begin
                        r_k         <= w_nk;
                        r_rd_en     <= 1'b1;
                        r_rd_addr_a <= w_na;
                        r_rd_addr_b <= w_nb;
                        r_tw_iss    <= w_ntw;
                    end
                end
                DRAIN: begin
                    if (r_dcnt == DW'(D - 1)) begin
                        if (r_stage == LOG2N'(LOG2N - 1)) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= ISSUE;
                            r_stage     <= w_ns;
                            r_k         <= '0;
                            r_rd_en     <= 1'b1;
                            r_rd_addr_a <= w_na;
                            r_rd_addr_b <= w_nb;
                            r_tw_iss    <= w_ntw;
                        end
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Position i of the pipe holds the operation issued i cycles ago.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i <= D; i++) begin
                r_pv[i] <= 1'b0;
                r_pa[i] <= '0;
                r_pb[i] <= '0;
            end
        end else begin
            r_pv[1] <= r_rd_en;
            r_pa[1] <= r_rd_addr_a;
            r_pb[1] <= r_rd_addr_b;
            for (int i = 2; i <= D; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pb[i] <= r_pb[i-1];
            end
        end
    end

    generate
        if (TW_DLY == 0) begin : g_tw_direct
            assign w_tw_out = r_tw_iss;
        end else if (TW_DLY == 1) begin : g_tw_one
            logic [KW-1:0] r_tw;
            always_ff @(posedge clk) begin
                if (reset)        r_tw <= '0;
                else if (r_rd_en) r_tw <= r_tw_iss;
            end
            assign w_tw_out = r_tw;
        end else begin : g_tw_pipe
            logic [KW-1:0] r_ptw [1:TW_DLY-1];
            logic [KW-1:0] r_tw;
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 1; i < TW_DLY; i++) r_ptw[i] <= '0;
                    r_tw <= '0;
                end else begin
                    r_ptw[1] <= r_tw_iss;
                    for (int i = 2; i < TW_DLY; i++) r_ptw[i] <= r_ptw[i-1];
                    if (r_pv[TW_DLY-1]) r_tw <= r_ptw[TW_DLY-1];
                end
            end
            assign w_tw_out = r_tw;
        end
    endgenerate

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr_a = r_rd_addr_a;
    assign bus.rd_addr_b = r_rd_addr_b;
    assign bus.tw_addr   = w_tw_out;
    assign bus.bf_enable = r_pv[MEM_RD_LAT];
    assign bus.wr_en     = r_pv[D];
    assign bus.wr_addr_a = r_pa[D];
    assign bus.wr_addr_b = r_pb[D];
    assign bus.stage_idx = r_stage;
    assign bus.sync_err  = r_sync_err;
endmodule

`default_nettype wire

// File: tb/tb_fft_bf_scheduler.sv
// ============================================================================
// Module      : tb_fft_bf_scheduler
// Description : Self-checking bench for fft_bf_scheduler (N=8, D=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_bf_scheduler;
    localparam int N     = 8;
    localparam int MRL   = 1;
    localparam int BFL   = 3;
    localparam int TWL   = 1;
    localparam int LOG2N = 3;
    localparam int HALF  = N / 2;
    localparam int D     = MRL + BFL;
    localparam int TWD   = MRL + 1 - TWL;
    localparam int PER   = HALF + D;
    localparam int TOTAL = 1 + LOG2N * PER;

    typedef struct {
        int cyc;
        bit wr;
        int a;
        int b;
        int tw;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   extra = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0] hist = '0;

    logic       rec_rd [0:31];
    logic       rec_wr [0:31];
    logic [2:0] rec_rda [0:31];
    logic [2:0] rec_rdb [0:31];
    logic [2:0] rec_wra [0:31];
    logic [2:0] rec_wrb [0:31];
    logic [1:0] rec_tw [0:31];
    vec_t       tbl [16];

    always #5 clk = ~clk;

    fft_bf_scheduler_if #(.N_POINTS(N)) bus ();

    fft_bf_scheduler #(
        .N_POINTS  (N),
        .MEM_RD_LAT(MRL),
        .BF_LATENCY(BFL),
        .TW_RD_LAT (TWL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Butterfly model: out_valid follows enable by BFL cycles (+extra when skewed).
    always @(posedge clk) begin
        if (reset) hist <= '0;
        else       hist <= {hist[6:0], bus.bf_enable};
    end
    assign bus.bf_out_valid = hist[BFL - 1 + extra];

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
        end
    endtask

    // Reference: cycle u (relative to the accepted start) issues butterfly k of stage s?
    function automatic bit model_issue(input int u, output int a, output int b, output int tw);
        int q, r, span;
        a = 0; b = 0; tw = 0;
        if (u < 1 || u > LOG2N * PER) return 1'b0;
        q = (u - 1) / PER;
        r = (u - 1) % PER;
        if (r >= HALF) return 1'b0;
        span = N >> (q + 1);
        a  = (r / span) * 2 * span + r % span;
        b  = a + span;
        tw = (r % span) * (1 << q);
        return 1'b1;
    endfunction

    task automatic check_cycle(input int c, input bit skewed);
        int a, b, tw, exp_tw;
        bit iss;
        iss = model_issue(c, a, b, tw);
        check("rd_en", c, bus.rd_en, iss);
        if (iss) begin
            check("rd_addr_a", c, bus.rd_addr_a, a);
            check("rd_addr_b", c, bus.rd_addr_b, b);
        end
        iss = model_issue(c - MRL, a, b, tw);
        check("bf_enable", c, bus.bf_enable, iss);
        iss = model_issue(c - D, a, b, tw);
        check("wr_en", c, bus.wr_en, iss);
        if (iss) begin
            check("wr_addr_a", c, bus.wr_addr_a, a);
            check("wr_addr_b", c, bus.wr_addr_b, b);
        end
        exp_tw = 0;
        for (int u = 1; u <= c - TWD; u++)
            if (model_issue(u, a, b, tw)) exp_tw = tw;
        check("tw_addr", c, bus.tw_addr, exp_tw);
        check("busy", c, bus.busy, (c >= 1 && c <= TOTAL - 1));
        check("done", c, bus.done, (c == TOTAL));
        if (c >= 1 && c <= TOTAL - 1) check("stage_idx", c, bus.stage_idx, (c - 1) / PER);
        check("sync_err", c, bus.sync_err, (skewed && c >= D + 2));
        rec_rd[c]  = bus.rd_en;
        rec_wr[c]  = bus.wr_en;
        rec_rda[c] = bus.rd_addr_a;
        rec_rdb[c] = bus.rd_addr_b;
        rec_wra[c] = bus.wr_addr_a;
        rec_wrb[c] = bus.wr_addr_b;
        rec_tw[c]  = bus.tw_addr;
    endtask

    // Called #1 after a clock edge; start is sampled at the next edge (cycle 0).
    task automatic run_transform(input bit skewed, input bit rnd_start);
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= TOTAL + 2; c++) begin
            check_cycle(c, skewed);
            if (rnd_start && c <= TOTAL)
                bus.start = (c == 10) || ($urandom_range(0, 3) == 0);
            else
                bus.start = 1'b0;
            if (c < TOTAL + 2) begin
                @(posedge clk); #1;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, 4, 0};  tbl[1]  = '{2, 0, 1, 5, 1};
        tbl[2]  = '{3, 0, 2, 6, 2};  tbl[3]  = '{4, 0, 3, 7, 3};
        tbl[4]  = '{9, 0, 0, 2, 0};  tbl[5]  = '{10, 0, 1, 3, 2};
        tbl[6]  = '{11, 0, 4, 6, 0}; tbl[7]  = '{12, 0, 5, 7, 2};
        tbl[8]  = '{17, 0, 0, 1, 0}; tbl[9]  = '{18, 0, 2, 3, 0};
        tbl[10] = '{19, 0, 4, 5, 0}; tbl[11] = '{20, 0, 6, 7, 0};
        tbl[12] = '{5, 1, 0, 4, 0};  tbl[13] = '{6, 1, 1, 5, 0};
        tbl[14] = '{7, 1, 2, 6, 0};  tbl[15] = '{8, 1, 3, 7, 0};

        reset = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 0, bus.busy, 0);
        check("rst_done", 0, bus.done, 0);
        check("rst_rd_en", 0, bus.rd_en, 0);
        check("rst_wr_en", 0, bus.wr_en, 0);
        check("rst_bf_enable", 0, bus.bf_enable, 0);
        check("rst_sync_err", 0, bus.sync_err, 0);
        check("rst_tw_addr", 0, bus.tw_addr, 0);
        check("rst_stage_idx", 0, bus.stage_idx, 0);
        reset = 1'b0;
        idle(1);

        run_transform(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) begin
                check("tbl_wr_en", tbl[i].cyc, rec_wr[tbl[i].cyc], 1);
                check("tbl_wr_a", tbl[i].cyc, rec_wra[tbl[i].cyc], tbl[i].a);
                check("tbl_wr_b", tbl[i].cyc, rec_wrb[tbl[i].cyc], tbl[i].b);
            end else begin
                check("tbl_rd_en", tbl[i].cyc, rec_rd[tbl[i].cyc], 1);
                check("tbl_rd_a", tbl[i].cyc, rec_rda[tbl[i].cyc], tbl[i].a);
                check("tbl_rd_b", tbl[i].cyc, rec_rdb[tbl[i].cyc], tbl[i].b);
                check("tbl_tw", tbl[i].cyc + TWD, rec_tw[tbl[i].cyc + TWD], tbl[i].tw);
            end
        end

        for (int r = 0; r < 3; r++) begin
            idle($urandom_range(0, 3));
            run_transform(1'b0, 1'b1);
        end

        // Butterfly answering one cycle late: sticky error until next start.
        idle(2);
        extra = 1;
        run_transform(1'b1, 1'b0);
        idle(4);
        extra = 0;
        check("sync_err_sticky", 0, bus.sync_err, 1);
        idle(2);
        check("sync_err_idle", 0, bus.sync_err, 1);
        run_transform(1'b0, 1'b0);

        // Reset during the first drain aborts; a later start restarts at stage 0.
        idle(2);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check_cycle(c, 1'b0);
            if (c < 6) begin
                @(posedge clk); #1;
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 7, bus.busy, 0);
        check("abort_rd_en", 7, bus.rd_en, 0);
        check("abort_wr_en", 7, bus.wr_en, 0);
        check("abort_bf_enable", 7, bus.bf_enable, 0);
        check("abort_done", 7, bus.done, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_idle_rd_en", 8, bus.rd_en, 0);
        run_transform(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
